apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Shares one apb_master among NUM_REQ local requesters. Round-robin pick, latches the winner's
//  addr/wdata/write, pulses apb_master.transfer once, watches the APB bus for the completing
//  access phase, then returns a per-requester done pulse. One transfer in flight at a time.
//  Sits between client logic and apb_master; a stall watchdog flags PREADY hangs.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  ADDR_W    32   address width
//  DATA_W    32   write data width
//  STALL_MAX 16   wait-phase cycles before stall_err is raised (>=2)
// PORTS
//  clk          in   1               clock, rising edge
//  reset_n      in   1               asynchronous active-low reset
//  req          in   NUM_REQ         per-requester request; held until done[i]
//  req_addr     in   NUM_REQ*ADDR_W  packed, slice i = requester i
//  req_wdata    in   NUM_REQ*DATA_W  packed, slice i = requester i
//  req_write    in   NUM_REQ         1 = write, 0 = read
//  grant        out  NUM_REQ         one-hot owner of the in-flight transfer
//  done         out  NUM_REQ         one-cycle completion pulse to owner
//  busy         out  1               transfer in flight (state != IDLE)
//  stall_err    out  1               sticky until completion: wait exceeded STALL_MAX
//  transfer     out  1               to apb_master: start strobe
//  addr         out  ADDR_W          to apb_master: registered winner address
//  wdata        out  DATA_W          to apb_master: registered winner data
//  write        out  1               to apb_master: registered winner direction
//  PSELx        in   1               APB bus monitor
//  PENABLE      in   1               APB bus monitor
//  PREADY       in   1               APB bus monitor
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; rr_ptr=0 (requester 0 highest priority); stall counter 0.
//  FSM (all outputs registered):
//   IDLE  : if |req -> pick first set bit searching from rr_ptr upward with wrap; latch its
//           addr/wdata/write; grant<=onehot(win); transfer<=1; ->ISSUE. Else stay, transfer=0.
//   ISSUE : transfer<=0 (exactly one high cycle); stall counter cleared; ->WAIT.
//   WAIT  : complete = PSELx & PENABLE & PREADY sampled at posedge.
//           complete -> done[win]<=1, rr_ptr<=(win+1)%NUM_REQ, stall_err<=0, ->DONE.
//           else counter++ (saturates); counter==STALL_MAX-1 -> stall_err<=1; stay in WAIT
//           (never abandons a bus access; APB has no abort).
//   DONE  : done<=0; grant<=0; ->IDLE. Requester must drop or re-present req this cycle.
//  Latency: req rising sampled at edge k -> grant+transfer at k+1 -> done pulse one cycle
//   after the completing access-phase edge. Min req-to-done: 4 cycles with zero-wait slave.
//  Fairness: with all req held, grants rotate 0,1,2,3,0,...; a requester waits <= NUM_REQ-1
//   transfers.
//  addr/wdata/write stable from grant until done; changes on req_* while granted ignored.
//  req[i] dropped while granted: transfer still completes, done[i] still pulses.
//  New req arriving in WAIT/DONE only considered back in IDLE.
//  PREADY high outside access phase (PENABLE=0) ignored.
//  Async reset mid-transfer: immediate return to reset values; no done pulse;
//   apb_master shares reset_n so the bus is also idled.
//  rr_ptr width = clog2(NUM_REQ); increment wraps modulo NUM_REQ (non-power-of-2 legal).
// STRUCTURE
//  Package apb_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3),
//   default ADDR_W/DATA_W, and the APB completion predicate as a function.
//  Sub-module rr_pick (combinational): inputs req, rr_ptr; outputs any, win_idx, win_onehot
//   via rotate / priority-encode / un-rotate. Top holds FSM, data latches, stall counter.
// TESTING (bench drives apb_master + behavioural slave model)
//  1 Single write: req=4'b0100, addr 0xABCD_1234, wdata 0xFACE_CAFE, slave PREADY after 3
//    wait cycles -> grant=4'b0100, one transfer pulse, bus write to 0xABCD_1234, done[2] once.
//  2 All four req held, zero-wait slave -> grants in order 0,1,2,3,0; each done in own slot;
//    never two grant bits set.
//  3 Req[1] alone twice back to back, then req[0] and req[1] together -> rr_ptr=2 so req[0]
//    wins (wrap), req[1] next.
//  4 Slave withholds PREADY 20 cycles, STALL_MAX=16 -> stall_err rises on wait cycle 16,
//    stays high; clears with done when PREADY finally asserts; no second transfer pulse.
//  5 reset_n low in WAIT -> grant, done, busy, transfer, stall_err all 0 at once; after
//    release, pending req[3] re-arbitrated from rr_ptr=0.
//  6 Read (req_write=0) while requester changes req_addr mid-WAIT -> PADDR holds latched value.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB request arbiter.
//   - FSM state encoding (kept as plain 2-bit constants so legacy tools and
//     waveform viewers see stable values).
//   - Default bus widths.
//   - The APB completion predicate: an access phase finishes on the edge where
//     PSELx, PENABLE and PREADY are all high.
package apb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // PREADY during the setup phase (PENABLE low) does not end a transfer.
    function automatic logic apb_complete(input logic psel, input logic penable,
                                          input logic pready);
        return psel & penable & pready;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   rr_ptr     : index of the requester with highest priority this round
//   any        : at least one request is set
//   win_idx    : index of the winner (first set bit at or above rr_ptr, wrapping)
//   win_onehot : one-hot form of win_idx, all zero when nothing is requested
// Works for any NUM_REQ >= 2, including non powers of two, because every
// index step wraps modulo NUM_REQ rather than relying on bit truncation.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               any,
    output logic [PTR_W-1:0]   win_idx,
    output logic [NUM_REQ-1:0] win_onehot
);

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PTR_W'(sum);
    endfunction

    logic [NUM_REQ-1:0] rot;
    logic [PTR_W-1:0]   pos;
    logic               found;

    // Rotate so rr_ptr sits at bit 0, priority-encode from bit 0, then
    // un-rotate the found position back to a requester index.
    // NOTE: every variable written here gets a default first so no path
    // leaves it holding its old value, which would infer a latch.
    always_comb begin
        rot        = '0;
        pos        = '0;
        found      = 1'b0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[wrap_add(rr_ptr, i)];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                pos   = PTR_W'(i);
                found = 1'b1;
            end
        end
        any     = found;
        win_idx = wrap_add(rr_ptr, int'(pos));
        if (found) win_onehot[win_idx] = 1'b1;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one apb_master among NUM_REQ local requesters.
// Picks a winner round-robin, latches its addr/wdata/write, pulses transfer
// for one cycle, watches the APB bus for the completing access phase, then
// pulses done[winner]. One transfer in flight at a time.
// Ports:
//   clk, reset_n                     clock / asynchronous active-low reset
//   req, req_addr, req_wdata, req_write   requester side (packed slices)
//   grant, done, busy, stall_err     status back to requesters
//   transfer, addr, wdata, write     command to apb_master
//   PSELx, PENABLE, PREADY           APB bus monitor inputs
// A stall watchdog raises stall_err once the wait phase reaches STALL_MAX
// cycles; the transfer is never abandoned since APB has no abort.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STALL_MAX = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_write,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic                      stall_err,
    output logic                      transfer,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         wdata,
    output logic                      write,
    input  logic                      PSELx,
    input  logic                      PENABLE,
    input  logic                      PREADY
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STALL_MAX + 1);

    // Unpack requester slices so the winner can be selected by index.
    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    logic [1:0]         state_q,     state_d;
    logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [PTR_W-1:0]   win_q,       win_d;
    logic [NUM_REQ-1:0] grant_q,     grant_d;
    logic [NUM_REQ-1:0] done_q,      done_d;
    logic               busy_q,      busy_d;
    logic               stall_err_q, stall_err_d;
    logic               transfer_q,  transfer_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [DATA_W-1:0]  wdata_q,     wdata_d;
    logic               write_q,     write_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .any        (pick_any),
        .win_idx    (pick_idx),
        .win_onehot (pick_onehot)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        grant_d     = grant_q;
        done_d      = done_q;
        stall_err_d = stall_err_q;
        transfer_d  = transfer_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_IDLE: begin
                transfer_d = 1'b0;
                if (pick_any) begin
                    win_d      = pick_idx;
                    grant_d    = pick_onehot;
                    addr_d     = addr_arr[pick_idx];
                    wdata_d    = wdata_arr[pick_idx];
                    write_d    = req_write[pick_idx];
                    transfer_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                transfer_d  = 1'b0;
                stall_cnt_d = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (apb_complete(PSELx, PENABLE, PREADY)) begin
                    done_d      = grant_q;
                    rr_ptr_d    = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
                    stall_err_d = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    // Saturating counter; the flag is raised on the edge that
                    // completes the STALL_MAX-th waiting cycle and then stays.
                    if (stall_cnt_q != CNT_W'(STALL_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
                    if (stall_cnt_q == CNT_W'(STALL_MAX - 1)) stall_err_d = 1'b1;
                end
            end
            default: begin  // ST_DONE
                done_d  = '0;
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            stall_err_q <= 1'b0;
            transfer_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            stall_err_q <= stall_err_d;
            transfer_q  <= transfer_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign stall_err = stall_err_q;
    assign transfer  = transfer_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign write     = write_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter. Models an apb_master plus a slave with a
// programmable number of access-phase wait cycles, and predicts the winner of
// each arbitration from the round-robin rule (first requester at or above the
// pointer, wrapping; pointer moves past each completed winner).
module tb_apb_req_arbiter;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [AW-1:0]   r_addr  [N];
    logic [DW-1:0]   r_wdata [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;

    logic [N-1:0]  grant, done;
    logic          busy, stall_err, transfer, wr_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          PSELx = 1'b0, PENABLE = 1'b0, PREADY = 1'b0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = r_addr[i];
            req_wdata[i*DW +: DW] = r_wdata[i];
        end
    end

    apb_req_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STALL_MAX(SMAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .stall_err (stall_err),
        .transfer  (transfer),
        .addr      (addr_o),
        .wdata     (wdata_o),
        .write     (wr_o),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PREADY    (PREADY)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- apb_master + slave model ----------------
    int            m_state  = 0;   // 0 idle, 1 setup, 2 access
    int            wcnt     = 0;
    int            wait_n   = 0;   // access-phase cycles before PREADY
    bit            stray    = 0;   // drive PREADY high during setup too
    int            tr_count = 0;
    bit            complete_edge = 0;
    logic [AW-1:0] log_addr;
    logic [DW-1:0] log_wdata;
    logic          log_write;
    logic [N-1:0]  req_s1 = '0;    // req as sampled on the latest edge

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; wcnt = 0; complete_edge = 0;
            PSELx = 1'b0; PENABLE = 1'b0; PREADY = 1'b0;
        end else begin
            req_s1        = req;
            complete_edge = 0;
            if (transfer) tr_count++;
            case (m_state)
                0: if (transfer) begin
                    m_state   = 1;
                    log_addr  = addr_o;
                    log_wdata = wdata_o;
                    log_write = wr_o;
                end
                1: begin m_state = 2; wcnt = 0; end
                default: if (PREADY) begin complete_edge = 1; m_state = 0; end
                         else wcnt++;
            endcase
            #1;
            PSELx   = (m_state != 0);
            PENABLE = (m_state == 2);
            PREADY  = (m_state == 2 && wcnt >= wait_n) || (m_state == 1 && stray);
        end
    end

    // ---------------- reference model ----------------
    int ptr_m    = 0;
    int last_lat = 0;

    function automatic int rr_ref(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // One complete transaction: arbitration, bus access, done pulse, release.
    task automatic xact(input string tag, input bit keep_req, input bit mid_change,
                        output int win);
        int exp_w, n, tr0;
        bit seen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_write;
        win = -1; seen = 0; last_lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (transfer) begin seen = 1; last_lat = i; break; end
        end
        if (!seen) begin chk({tag, "_xfer_timeout"}, 0, 1); return; end
        exp_w = rr_ref(req_s1, ptr_m);
        if (exp_w < 0) begin chk({tag, "_spurious_xfer"}, 0, 1); return; end
        for (int i = 0; i < N; i++) if (grant[i]) win = i;
        chk({tag, "_grant"}, grant, 64'(1) << exp_w);
        chk({tag, "_busy"}, busy, 1);
        e_addr = r_addr[exp_w]; e_wdata = r_wdata[exp_w]; e_write = req_write[exp_w];
        tr0 = tr_count;
        @(negedge clk);
        chk({tag, "_one_pulse"}, transfer, 0);
        n = 0; seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done != '0) begin seen = 1; break; end
            n++;
            chk({tag, "_stall"}, stall_err, (n >= SMAX) ? 1 : 0);
            chk({tag, "_grant_hold"}, grant, 64'(1) << exp_w);
            if (mid_change && n == 2) begin
                r_addr[exp_w] = ~r_addr[exp_w];
                req[exp_w]    = 1'b0;
            end
        end
        if (!seen) begin chk({tag, "_done_timeout"}, 0, 1); return; end
        chk({tag, "_done"}, done, 64'(1) << exp_w);
        chk({tag, "_done_timing"}, complete_edge, 1);
        chk({tag, "_stall_clr"}, stall_err, 0);
        chk({tag, "_addr_held"}, addr_o, e_addr);
        chk({tag, "_bus_addr"}, log_addr, e_addr);
        chk({tag, "_bus_write"}, log_write, e_write);
        if (e_write) chk({tag, "_bus_wdata"}, log_wdata, e_wdata);
        chk({tag, "_xfer_count"}, tr_count - tr0, 1);
        ptr_m = (exp_w + 1) % N;
        if (!keep_req) req[exp_w] = 1'b0;
        @(negedge clk);
        chk({tag, "_done_end"}, done, 0);
        chk({tag, "_grant_end"}, grant, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        req = '0; stray = 0; wait_n = 0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ptr_m = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, seen;
        logic [N-1:0] nr;
        req = '0; req_write = '0;
        for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_wdata[i] = '0; end

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_transfer", transfer, 0);
        chk("rst_stall", stall_err, 0);
        chk("rst_addr", addr_o, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        ptr_m = 0;

        // 1: single write, three wait cycles
        r_addr[2] = 32'hABCD_1234; r_wdata[2] = 32'hFACE_CAFE; req_write[2] = 1'b1;
        wait_n = 3;
        @(negedge clk);
        req = 4'b0100;
        xact("t1", 0, 0, w);
        chk("t1_winner", w, 2);
        chk("t1_latency", last_lat, 1);
        chk("t1_paddr", log_addr, 32'hABCD_1234);
        chk("t1_pwdata", log_wdata, 32'hFACE_CAFE);

        // 2: all four held, zero-wait slave: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) begin
            r_addr[i] = 32'h1000_0000 + i; r_wdata[i] = 32'h5A00_0000 + i; req_write[i] = i[0];
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            xact("t2", 1, 0, w);
            chk("t2_rotation", w, k % N);
        end
        req = '0;

        // 3: req[1] twice, then req[0]+req[1] -> 0 wins by wrap, then 1
        do_reset();
        wait_n = 1;
        req = 4'b0010;
        xact("t3a", 1, 0, w); chk("t3_first", w, 1);
        xact("t3b", 1, 0, w); chk("t3_second", w, 1);
        req[0] = 1'b1;
        xact("t3c", 0, 0, w); chk("t3_wrap", w, 0);
        xact("t3d", 0, 0, w); chk("t3_next", w, 1);

        // 4: slave withholds PREADY for 20 access cycles
        wait_n = 20;
        req = 4'b0001;
        xact("t4", 0, 0, w);

        // PREADY high during setup phase must not complete the access
        wait_n = 2; stray = 1;
        req = 4'b0100;
        xact("stray", 0, 0, w);
        stray = 0;

        // 6: read, requester changes addr and drops req mid-WAIT
        r_addr[1] = 32'h0000_BEEF; req_write[1] = 1'b0; wait_n = 4;
        req = 4'b0010;
        xact("t6", 0, 1, w);
        chk("t6_read", log_write, 0);

        // 5: reset while in WAIT with stall_err raised
        r_addr[3] = 32'h3333_0000; req_write[3] = 1'b1; wait_n = 40;
        req = 4'b1000;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (transfer) begin seen = 1; break; end
        end
        chk("t5_xfer_seen", seen, 1);
        repeat (20) @(negedge clk);
        chk("t5_stall_pre", stall_err, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_grant", grant, 0);
        chk("t5_done", done, 0);
        chk("t5_busy", busy, 0);
        chk("t5_transfer", transfer, 0);
        chk("t5_stall", stall_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ptr_m = 0; wait_n = 0;
        xact("t5_rearb", 0, 0, w);
        chk("t5_winner", w, 3);

        // Randomised traffic against the reference model
        for (int k = 0; k < 40; k++) begin
            nr = N'($urandom_range(0, (1 << N) - 1));
            if ((req | nr) == '0) nr[$urandom_range(0, N - 1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (nr[i] && !req[i]) begin
                    r_addr[i]    = $urandom;
                    r_wdata[i]   = $urandom;
                    req_write[i] = 1'($urandom_range(0, 1));
                end
            end
            req    = req | nr;
            wait_n = $urandom_range(0, 3);
            stray  = 1'($urandom_range(0, 1));
            xact("rnd", 1'($urandom_range(0, 1)), 0, w);
        end
        req = '0;
        repeat (3) @(negedge clk);
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
